osequencer_gen: RTL



---
 rtl/osequencer_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/osequencer_gen.sv
// ============================================================================
// osequencer_gen
// Seeded-LFSR game sequence buffer: generate, append, and stream playback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module osequencer_gen #(
    parameter int          DATA_W = 4,
    parameter int          DEPTH  = 32,
    parameter int          ADDR_W = 5,
    parameter logic [15:0] SEED   = 16'hBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_gen,
    input  logic [ADDR_W:0]   len,
    input  logic              append,
    input  logic              play,
    input  logic              seed_load,
    input  logic [15:0]       seed_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W:0]   seq_len,
    output logic              busy,
    output logic              finish,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GEN    = 3'd1,
        S_APPEND = 3'd2,
        S_PLAY   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [ADDR_W:0]     seq_len_q, seq_len_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                ovf_q, ovf_d;
    logic                wr_en;
    logic [15:0]         lfsr_step;
    logic                last_entry;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign last_entry = ({1'b0, rd_q} == (seq_len_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        seq_len_d = seq_len_q;
        len_d     = len_q;
        rd_d      = rd_q;
        ovf_d     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
                end else if (start_gen) begin
                    len_d     = (len > DEPTH_L) ? DEPTH_L : len;
                    seq_len_d = '0;
                    state_d   = S_GEN;
                end else if (append) begin
                    if (seq_len_q == DEPTH_L) begin
                        ovf_d = 1'b1;
                    end else begin
                        state_d = S_APPEND;
                    end
                end else if (play) begin
                    rd_d    = '0;
                    state_d = (seq_len_q == '0) ? S_DONE : S_PLAY;
                end
            end
            S_GEN: begin
                // seq_len doubles as the write pointer; one extra cycle once full
                if (seq_len_q < len_q) begin
                    wr_en     = 1'b1;
                    lfsr_d    = lfsr_step;
                    seq_len_d = seq_len_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_APPEND: begin
                wr_en     = 1'b1;
                lfsr_d    = lfsr_step;
                seq_len_d = seq_len_q + 1'b1;
                state_d   = S_DONE;
            end
            S_PLAY: begin
                if (out_ready) begin
                    if (last_entry) begin
                        rd_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            seq_len_q <= '0;
            len_q     <= '0;
            rd_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            seq_len_q <= seq_len_d;
            len_q     <= len_d;
            rd_q      <= rd_d;
            ovf_q     <= ovf_d;
        end
    end

    // Buffer contents survive reset; writes are suppressed while reset is high
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[seq_len_q[ADDR_W-1:0]] <= lfsr_q[DATA_W-1:0];
        end
    end

    assign out_valid = (state_q == S_PLAY);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign out_last  = out_valid && last_entry;
    assign seq_len   = seq_len_q;
    assign busy      = (state_q != S_IDLE);
    assign finish    = (state_q == S_DONE);
    assign overflow  = ovf_q;

endmodule

`default_nettype wire
